// File: rtl/mips_mem_arbiter.sv
// rtl/mips_mem_arbiter.sv - shares one byte-wide memory port between the MIPS core and the host loader
// Optional build macro MEM_ARB_HOST_PRIORITY_EN: host wins every IDLE tie unless the CPU lock is honoured.
module mips_mem_arbiter #(
  parameter int AWIDTH      = 8,
  parameter int DWIDTH      = 8,
  parameter int WAIT_CYCLES = 1,
  parameter int LOCK_MAX    = 4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_lock,
  input  logic [AWIDTH-1:0] cpu_adr,
  input  logic [DWIDTH-1:0] cpu_wdata,
  output logic [DWIDTH-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [AWIDTH-1:0] host_adr,
  input  logic [DWIDTH-1:0] host_wdata,
  output logic [DWIDTH-1:0] host_rdata,
  output logic              host_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_adr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              grant_host
);

  localparam int              LCW        = $clog2(LOCK_MAX + 1);
  localparam logic [LCW-1:0]  LOCK_MAX_C = LCW'(LOCK_MAX);
  localparam logic [2:0]      WAIT_LAST  = 3'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t            state_q, state_d;
  logic              last_host_q, last_host_d;
  logic [LCW-1:0]    lock_cnt_q, lock_cnt_d;
  logic [2:0]        wait_cnt_q, wait_cnt_d;
  logic              win_host_q, win_host_d;
  logic              acc_we_q, acc_we_d;
  logic [AWIDTH-1:0] acc_adr_q, acc_adr_d;
  logic [DWIDTH-1:0] acc_wdata_q, acc_wdata_d;
  logic [DWIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DWIDTH-1:0] host_rdata_q, host_rdata_d;

  logic lock_honoured;
  logic any_req;
  logic pick_host;

  // The lock only counts once the CPU already holds the port, so a fetch burst stays together.
  always_comb begin
    lock_honoured = cpu_lock && !last_host_q && (lock_cnt_q < LOCK_MAX_C);
    any_req       = cpu_req || host_req;
`ifdef MEM_ARB_HOST_PRIORITY_EN
    pick_host     = host_req && !(cpu_req && lock_honoured);
`else
    if (cpu_req && host_req) begin
      pick_host = lock_honoured ? 1'b0 : !last_host_q;
    end else begin
      pick_host = host_req;
    end
`endif
  end

  always_comb begin
    state_d      = state_q;
    last_host_d  = last_host_q;
    lock_cnt_d   = lock_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    win_host_d   = win_host_q;
    acc_we_d     = acc_we_q;
    acc_adr_d    = acc_adr_q;
    acc_wdata_d  = acc_wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;

    if (!cpu_lock) begin
      lock_cnt_d = '0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d     = S_ISSUE;
          win_host_d  = pick_host;
          last_host_d = pick_host;
          acc_we_d    = pick_host ? host_we    : cpu_we;
          acc_adr_d   = pick_host ? host_adr   : cpu_adr;
          acc_wdata_d = pick_host ? host_wdata : cpu_wdata;
          if (pick_host) begin
            lock_cnt_d = '0;
          end else if (cpu_lock && (lock_cnt_q < LOCK_MAX_C)) begin
            lock_cnt_d = lock_cnt_q + LCW'(1);
          end
        end
      end
      S_ISSUE: begin
        state_d    = S_WAIT;
        wait_cnt_d = '0;
      end
      S_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d = S_ACK;
          if (!acc_we_q) begin
            if (win_host_q) begin
              host_rdata_d = mem_rdata;
            end else begin
              cpu_rdata_d = mem_rdata;
            end
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end
      S_ACK: begin
        state_d    = S_IDLE;
        win_host_d = 1'b0;
      end
      default: begin
        state_d    = S_IDLE;
        win_host_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= S_IDLE;
      last_host_q  <= 1'b1;
      lock_cnt_q   <= '0;
      wait_cnt_q   <= '0;
      win_host_q   <= 1'b0;
      acc_we_q     <= 1'b0;
      acc_adr_q    <= '0;
      acc_wdata_q  <= '0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      last_host_q  <= last_host_d;
      lock_cnt_q   <= lock_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      win_host_q   <= win_host_d;
      acc_we_q     <= acc_we_d;
      acc_adr_q    <= acc_adr_d;
      acc_wdata_q  <= acc_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  // Outputs decode straight from registered state, so they are glitch-free and zero outside ISSUE.
  always_comb begin
    mem_en     = (state_q == S_ISSUE);
    mem_we     = mem_en && acc_we_q;
    mem_adr    = mem_en ? acc_adr_q : '0;
    mem_wdata  = mem_en ? acc_wdata_q : '0;
    cpu_ack    = (state_q == S_ACK) && !win_host_q;
    host_ack   = (state_q == S_ACK) && win_host_q;
    grant_host = win_host_q;
    cpu_rdata  = cpu_rdata_q;
    host_rdata = host_rdata_q;
    cpu_stall  = cpu_req && !cpu_ack;
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb/tb_mips_mem_arbiter.sv - directed vector bench for mips_mem_arbiter
module tb_mips_mem_arbiter;

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i = 1'b1;
  logic       cpu_req = 1'b0, cpu_we = 1'b0, cpu_lock = 1'b0;
  logic [7:0] cpu_adr = 8'h00, cpu_wdata = 8'h00;
  logic [7:0] cpu_rdata;
  logic       cpu_ack, cpu_stall;
  logic       host_req = 1'b0, host_we = 1'b0;
  logic [7:0] host_adr = 8'h00, host_wdata = 8'h00;
  logic [7:0] host_rdata;
  logic       host_ack;
  logic       mem_en, mem_we;
  logic [7:0] mem_adr, mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic       grant_host;

  always #5 wb_clk_i = ~wb_clk_i;

  mips_mem_arbiter dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_lock   (cpu_lock),
    .cpu_adr    (cpu_adr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ack    (cpu_ack),
    .cpu_stall  (cpu_stall),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_adr   (host_adr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .host_ack   (host_ack),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_adr    (mem_adr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .grant_host (grant_host)
  );

  // Memory with one cycle of read latency; returns 0xEE whenever no read was issued.
  logic [7:0] mem [256];
  always @(posedge wb_clk_i) begin
    if (mem_en && mem_we) mem[mem_adr] <= mem_wdata;
    mem_rdata <= (mem_en && !mem_we) ? mem[mem_adr] : 8'hEE;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit         host;
    bit         we;
    logic [7:0] adr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];

  task automatic do_reset();
    wb_rst_i = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_lock = 1'b0;
    host_req = 1'b0; host_we = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int         en_k = -1;
    int         ack_k = -1;
    logic [7:0] adr_s = 8'h00, wd_s = 8'h00, rd = 8'h00;
    logic       we_s = 1'b0, gh_s = 1'b0, st_s = 1'b0;
    @(negedge wb_clk_i);
    if (v.host) begin
      host_req = 1'b1; host_we = v.we; host_adr = v.adr; host_wdata = v.wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = v.we; cpu_adr = v.adr; cpu_wdata = v.wdata;
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge wb_clk_i);
      if (mem_en && en_k < 0) begin
        en_k = k; adr_s = mem_adr; we_s = mem_we; wd_s = mem_wdata;
        gh_s = grant_host; st_s = cpu_stall;
      end
      if (v.host ? host_ack : cpu_ack) begin
        ack_k = k;
        rd = v.host ? host_rdata : cpu_rdata;
        break;
      end
    end
    cpu_req = 1'b0; host_req = 1'b0;
    check({tag, "_en_cycle"}, en_k, 1);
    check({tag, "_ack_cycle"}, ack_k, 3);
    check({tag, "_mem_adr"}, adr_s, v.adr);
    check({tag, "_mem_we"}, we_s, v.we);
    check({tag, "_mem_wdata"}, wd_s, v.wdata);
    check({tag, "_grant_host"}, gh_s, v.host);
    check({tag, "_cpu_stall"}, st_s, !v.host);
    check({tag, "_rdata"}, rd, v.exp_rdata);
    @(negedge wb_clk_i);
    check({tag, "_ack_pulse"}, v.host ? host_ack : cpu_ack, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         c_en_k, c_ack_k, h_ack_k, we_cnt, we_k, en_cnt, n, cpu_n;
    logic [7:0] crd, hadr, hwd;
    logic [6:0] order;
    bit         ack_seen;
    vec_t       v;

    for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    #1;
    mem[8'h10] <= 8'hA5;
    mem[8'h11] <= 8'h3C;
    mem[8'h04] <= 8'h4C;
    mem[8'hFF] <= 8'hC3;
    mem[8'h00] <= 8'h81;

    vecs[0] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'hA5};
    vecs[1] = '{1'b1, 1'b1, 8'h20, 8'h5A, 8'h00};
    vecs[2] = '{1'b1, 1'b0, 8'h20, 8'h00, 8'h5A};
    vecs[3] = '{1'b0, 1'b0, 8'h11, 8'h00, 8'h3C};
    vecs[4] = '{1'b0, 1'b1, 8'h40, 8'h77, 8'h3C};
    vecs[5] = '{1'b0, 1'b0, 8'h40, 8'h00, 8'h77};
    vecs[6] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'hC3};
    vecs[7] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h81};

    do_reset();
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_host_ack", host_ack, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_adr", mem_adr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_host_rdata", host_rdata, 0);
    check("rst_grant_host", grant_host, 0);
    check("rst_cpu_stall", cpu_stall, 0);

    // Simultaneous CPU read and host write straight after reset.
    @(negedge wb_clk_i);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 8'h04; cpu_wdata = 8'h00;
    host_req = 1'b1; host_we = 1'b1; host_adr = 8'h20; host_wdata = 8'h5A;
    c_en_k = -1; c_ack_k = -1; h_ack_k = -1; we_cnt = 0; we_k = -1; en_cnt = 0;
    crd = 8'h00; hadr = 8'h00; hwd = 8'h00;
    for (int k = 1; k <= 12; k++) begin
      @(negedge wb_clk_i);
      if (mem_en) en_cnt++;
      if (mem_we) begin we_cnt++; we_k = k; hadr = mem_adr; hwd = mem_wdata; end
      if (mem_en && !grant_host && c_en_k < 0) c_en_k = k;
      if (cpu_ack) begin c_ack_k = k; crd = cpu_rdata; cpu_req = 1'b0; end
      if (host_ack) begin h_ack_k = k; host_req = 1'b0; end
    end
    check("tie_cpu_en_cycle", c_en_k, 1);
    check("tie_cpu_ack_cycle", c_ack_k, 3);
    check("tie_cpu_rdata", crd, 8'h4C);
    check("tie_host_ack_cycle", h_ack_k, 7);
    check("tie_mem_en_count", en_cnt, 2);
    check("tie_we_count", we_cnt, 1);
    check("tie_we_cycle", we_k, 5);
    check("tie_host_adr", hadr, 8'h20);
    check("tie_host_wdata", hwd, 8'h5A);

    for (int i = 0; i < 8; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // Locked CPU burst against a persistent host request.
    do_reset();
    @(negedge wb_clk_i);
    cpu_lock = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 8'h10;
    host_req = 1'b1; host_we = 1'b0; host_adr = 8'hFF;
    n = 0; cpu_n = 0; order = 7'h7F;
    for (int k = 1; k <= 100; k++) begin
      @(negedge wb_clk_i);
      if (cpu_ack || host_ack) begin
        order[n] = host_ack;
        n++;
        if (cpu_ack) cpu_n++;
        if (cpu_n == 6) begin cpu_req = 1'b0; cpu_lock = 1'b0; end
      end
      if (n >= 7) break;
    end
    host_req = 1'b0;
    check("lock_grant_count", n, 7);
    for (int i = 0; i < 7; i++) check($sformatf("lock_grant%0d_is_host", i), order[i], (i == 4));

    // Reset during WAIT of a CPU read drops the access.
    repeat (2) @(negedge wb_clk_i);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 8'h10;
    @(negedge wb_clk_i);
    check("rstw_mem_en", mem_en, 1);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1; cpu_req = 1'b0;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    check("rstw_cpu_ack", cpu_ack, 0);
    check("rstw_cpu_rdata", cpu_rdata, 0);
    check("rstw_mem_en", mem_en, 0);
    check("rstw_mem_adr", mem_adr, 0);
    check("rstw_grant_host", grant_host, 0);
    check("rstw_cpu_stall", cpu_stall, 0);
    ack_seen = 1'b0;
    repeat (5) begin
      @(negedge wb_clk_i);
      if (cpu_ack) ack_seen = 1'b1;
    end
    check("rstw_no_late_ack", ack_seen, 0);
    v = '{1'b0, 1'b0, 8'h11, 8'h00, 8'h3C};
    run_vec("rstw_retry", v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
